dht11_responder: RTL

- Synthesizable DHT11 sensor emulator; the responder end of the single-wire DHT11 protocol.
- Watches the open-drain data line for a host start pulse, then drives the standard response preamble and a 40-bit frame.
- Frame carries humidity, temperature and checksum.
- Used on-board or in simulation as the far end for the DHT11 host reader, with no physical sensor attached.

---
 rtl/dht11_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dht11_responder.sv
// ---------------------------------------------------------------------------
// dht11_responder
//   Synthesizable DHT11 sensor emulator (responder end of the single-wire
//   DHT11 protocol). Waits for a host start pulse on the open-drain data
//   line, then drives the response preamble followed by a 40-bit frame
//   {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
//
// Ports
//   CLK        system clock
//   RST_n      asynchronous active-low reset (releases the line at once)
//   I_HUM      humidity,    [15:8] integer byte, [7:0] decimal byte
//   I_TEMP     temperature, [15:8] integer byte, [7:0] decimal byte
//   I_ERR_INJ  (only with DHT11_ERR_INJ_EN) corrupt checksum bit 0
//   O_BUSY     high while a response frame is being driven
//   O_DONE     one-cycle pulse when a frame completes
//   IO_DHT11   open-drain data line, driven only to 0 or Z
//
// Optional feature macro: DHT11_ERR_INJ_EN
//   Defined: adds I_ERR_INJ, sampled when the frame is latched; when high
//   the transmitted checksum is inverted in bit 0.
// ---------------------------------------------------------------------------
module dht11_responder #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_DLY_US  = 30,
    parameter int PRE_US       = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [15:0] I_HUM,
    input  logic [15:0] I_TEMP,
`ifdef DHT11_ERR_INJ_EN
    input  logic        I_ERR_INJ,
`endif
    output logic        O_BUSY,
    output logic        O_DONE,
    inout  wire         IO_DHT11
);

    // Each phase ends when the counter reaches its last cycle (length - 1).
    localparam logic [23:0] START_CYC    = 24'(START_MIN_US * CLK_FREQ_MHZ);
    localparam logic [23:0] RESP_LAST    = 24'(RESP_DLY_US * CLK_FREQ_MHZ - 1);
    localparam logic [23:0] PRE_LAST     = 24'(PRE_US * CLK_FREQ_MHZ - 1);
    localparam logic [23:0] BIT_LOW_LAST = 24'(BIT_LOW_US * CLK_FREQ_MHZ - 1);
    localparam logic [23:0] BIT0_LAST    = 24'(BIT0_HIGH_US * CLK_FREQ_MHZ - 1);
    localparam logic [23:0] BIT1_LAST    = 24'(BIT1_HIGH_US * CLK_FREQ_MHZ - 1);

    typedef enum logic [3:0] {
        IDLE,
        HOST_LOW,
        LATCH,
        RESP_DLY,
        PRE_LOW,
        PRE_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        line_meta;
    logic        line_sync;
    logic [23:0] cnt;
    logic [39:0] frame;
    logic [5:0]  bit_idx;
    logic        drive_low;
    logic        drive_low_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic [7:0]  chk;
    logic        err_bit;
    logic [23:0] bit_high_last;

`ifdef DHT11_ERR_INJ_EN
    assign err_bit = I_ERR_INJ;
`else
    assign err_bit = 1'b0;
`endif

    // Checksum wraps naturally in the 8-bit result.
    assign chk           = I_HUM[15:8] + I_HUM[7:0] + I_TEMP[15:8] + I_TEMP[7:0];
    assign bit_high_last = frame[bit_idx] ? BIT1_LAST : BIT0_LAST;
    assign IO_DHT11      = drive_low ? 1'b0 : 1'bz;

    // Two-flop synchronizer; resets to the idle (pulled-up) level so a reset
    // release never looks like a host start.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source.
            line_meta <= IO_DHT11;
            line_sync <= line_meta;
        end
    end

    // State register, phase timer and registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drive_low <= 1'b0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
        end else begin
            state     <= next_state;
            drive_low <= drive_low_nxt;
            O_BUSY    <= busy_nxt;
            O_DONE    <= done_nxt;
            if (next_state != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 24'd1;
        end
    end

    // Frame capture and bit pointer.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            frame   <= '0;
            bit_idx <= '0;
        end else begin
            if (state == LATCH)
                frame <= {I_HUM, I_TEMP, chk ^ {7'd0, err_bit}};
            if (state == PRE_HIGH && next_state == BIT_LOW)
                bit_idx <= 6'd39;
            else if (state == BIT_HIGH && next_state == BIT_LOW)
                bit_idx <= bit_idx - 6'd1;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch
        // is inferred.
        next_state = state;
        unique case (state)
            IDLE:     if (!line_sync) next_state = HOST_LOW;
            HOST_LOW: if (line_sync) next_state = (cnt >= START_CYC) ? LATCH : IDLE;
            LATCH:    next_state = RESP_DLY;
            RESP_DLY: if (cnt == RESP_LAST) next_state = PRE_LOW;
            PRE_LOW:  if (cnt == PRE_LAST) next_state = PRE_HIGH;
            PRE_HIGH: if (cnt == PRE_LAST) next_state = BIT_LOW;
            BIT_LOW:  if (cnt == BIT_LOW_LAST) next_state = BIT_HIGH;
            BIT_HIGH: if (cnt == bit_high_last)
                          next_state = (bit_idx == 6'd0) ? END_LOW : BIT_LOW;
            END_LOW:  if (cnt == BIT_LOW_LAST) next_state = IDLE;
            default:  next_state = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so the line
        // and flags change on the same edge as the state itself.
        drive_low_nxt = (next_state == PRE_LOW) || (next_state == BIT_LOW) ||
                        (next_state == END_LOW);
        busy_nxt      = !(next_state inside {IDLE, HOST_LOW, LATCH});
        done_nxt      = (state == END_LOW) && (next_state == IDLE);
    end

endmodule
